// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the pushbutton-driven ALU sequencer.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
// Contents: state encoding, mode limit, WAIT timeout, flag bit positions.
package alu_seq_ctrl_pkg;

  // Sequencer state encoding. Kept as plain constants so that older code
  // which compares against raw 3-bit values still links against it.
  typedef logic [2:0] state_t;
  localparam state_t S_MODE   = 3'd0;
  localparam state_t S_LOAD_A = 3'd1;
  localparam state_t S_LOAD_B = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_WAIT   = 3'd4;
  localparam state_t S_SHOW   = 3'd5;

  // Highest selectable operation; the mode digit wraps back to 0 after it.
  localparam logic [3:0] MODE_MAX = 4'd9;

  // WAIT gives up once the cycle counter reaches this value.
  localparam logic [7:0] TIMEOUT = 8'd255;

  // Bit positions inside the 4-bit {N,Z,C,V} flag word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Next mode after a mode press; anything at or above MODE_MAX wraps to 0,
  // so the mode register can never leave the 0..9 range.
  function automatic logic [3:0] mode_next(input logic [3:0] m);
    return (m >= MODE_MAX) ? 4'd0 : m + 4'd1;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_btn_edge.sv
// Pushbutton conditioner: 2-flop synchronizer followed by a rising-edge detector.
// Latency: 3 clk from the button going high to the registered one-cycle pulse.
// Backpressure: none; one pulse per press however long the button is held.
// Ports: clk, rst_n (sync, active-low), btn (raw, async), pulse (1-cycle).
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      meta  <= btn;
      sync  <= meta;
      prev  <= sync;
      // Registered so the pulse is glitch-free and lasts exactly one cycle.
      pulse <= sync & ~prev;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Pushbutton sequencer: pick a mode, load A and B from switches, launch the ALU, show result.
// Latency: 3 clk press-to-pulse, FSM acts on the next edge; WAIT times out 256 clk after alu_start.
// Backpressure: none; presses during EXEC/WAIT and alu_done outside WAIT are dropped.
// Ports: clk, rst_n (sync, active-low), btn_mode/btn_go (raw), sw_operand;
//        alu_op/alu_a/alu_b/alu_start to the ALU, alu_done/alu_result/alu_flags back;
//        result/flags (latched), mode_digit, busy, err (timeout).
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_mode,
  input  logic         btn_go,
  input  logic [n-1:0] sw_operand,
  output logic [3:0]   alu_op,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic         alu_start,
  input  logic         alu_done,
  input  logic [n-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic [n-1:0] result,
  output logic [3:0]   flags,
  output logic [3:0]   mode_digit,
  output logic         busy,
  output logic         err
);

  logic       mode_p;
  logic       go_p;
  state_t     state;
  logic [3:0] mode;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;

  btn_edge u_mode_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_mode),
    .pulse (mode_p)
  );

  btn_edge u_go_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_go),
    .pulse (go_p)
  );

  assign cnt_nxt = cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_MODE;
      mode   <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      result <= '0;
      flags  <= '0;
      err    <= 1'b0;
      cnt    <= '0;
    end else begin
      // go is tested first everywhere so it wins over a simultaneous mode press.
      case (state)
        S_MODE: begin
          if (go_p)        state <= S_LOAD_A;
          else if (mode_p) mode  <= mode_next(mode);
        end
        S_LOAD_A: begin
          if (go_p) begin
            alu_a <= sw_operand;
            state <= S_LOAD_B;
          end else if (mode_p) begin
            state <= S_MODE;
          end
        end
        S_LOAD_B: begin
          if (go_p) begin
            alu_b <= sw_operand;
            state <= S_EXEC;
          end else if (mode_p) begin
            state <= S_MODE;
          end
        end
        S_EXEC: begin
          cnt   <= '0;
          err   <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt_nxt;
          // A completion in the very cycle the counter reaches TIMEOUT still
          // counts as success, so done is checked before the timeout.
          if (alu_done) begin
            result <= alu_result;
            flags  <= alu_flags;
            state  <= S_SHOW;
          end else if (cnt_nxt == TIMEOUT) begin
            err   <= 1'b1;
            state <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (go_p)        state <= S_LOAD_A;
          else if (mode_p) state <= S_MODE;
        end
        default: state <= S_MODE;
      endcase
    end
  end

  assign alu_op     = mode;
  assign mode_digit = mode;
  // Gated by rst_n so neither strobe is seen while reset is being applied,
  // even before the reset edge has moved the state back to MODE.
  assign alu_start  = rst_n & (state == S_EXEC);
  assign busy       = rst_n & ((state == S_EXEC) | (state == S_WAIT));

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed scenarios plus randomized operations
// checked against a transaction-level model of modes, operands and ALU outcomes.
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         btn_mode = 1'b0;
  logic         btn_go = 1'b0;
  logic [N-1:0] sw_operand = '0;
  logic         alu_done = 1'b0;
  logic [N-1:0] alu_result = '0;
  logic [3:0]   alu_flags = '0;
  logic [3:0]   alu_op;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic         alu_start;
  logic [N-1:0] result;
  logic [3:0]   flags;
  logic [3:0]   mode_digit;
  logic         busy;
  logic         err;

  alu_seq_ctrl #(.n(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_mode   (btn_mode),
    .btn_go     (btn_go),
    .sw_operand (sw_operand),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .result     (result),
    .flags      (flags),
    .mode_digit (mode_digit),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int start_cnt = 0;

  always @(posedge clk) if (alu_start === 1'b1) start_cnt++;

  // Reference model: user-visible quantities only.
  typedef enum int {P_MODE, P_LA, P_LB, P_SHOW} ph_t;
  ph_t          ph;
  int           m_mode;
  logic [N-1:0] m_a, m_b, m_res;
  logic [3:0]   m_flg;
  logic         m_err;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic press(input logic do_mode, input logic do_go, input int hold);
    @(negedge clk);
    btn_mode = do_mode;
    btn_go   = do_go;
    cyc(hold);
    btn_mode = 1'b0;
    btn_go   = 1'b0;
    cyc(5);
  endtask

  task automatic model_reset();
    ph = P_MODE; m_mode = 0; m_a = '0; m_b = '0; m_res = '0; m_flg = '0; m_err = 1'b0;
  endtask

  task automatic mode_btn();
    press(1'b1, 1'b0, 4);
    if (ph == P_MODE) m_mode = (m_mode + 1) % 10;
    else              ph = P_MODE;
  endtask

  task automatic go_btn();
    press(1'b0, 1'b1, 4);
    if (ph == P_LA) begin
      m_a = sw_operand;
      ph  = P_LB;
    end else begin
      ph = P_LA;
    end
  endtask

  // From LOAD_B: press go, answer alu_start after d cycles (d > 255 means never).
  task automatic launch(input int d, input logic [N-1:0] r, input logic [3:0] f,
                        input bit noise, input string tag);
    int s0;
    int first_err;
    bit found;
    s0 = start_cnt;
    m_b = sw_operand;
    alu_result = ~r;
    alu_flags  = ~f;
    found = 1'b0;
    @(negedge clk);
    btn_go = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (i == 3) btn_go = 1'b0;
      if (alu_start === 1'b1) found = 1'b1;
    end
    btn_go = 1'b0;
    if (!found) begin
      chk({tag, " start_seen"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, " alu_b"}, alu_b, m_b);
    chk({tag, " alu_a"}, alu_a, m_a);
    chk({tag, " alu_op"}, alu_op, m_mode);
    first_err = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      alu_done = 1'b0;
      if (err === 1'b1 && first_err < 0) first_err = k;
      if (noise) begin
        if (k == 20) btn_mode = 1'b1;
        if (k == 24) btn_mode = 1'b0;
        if (k == 40) btn_go = 1'b1;
        if (k == 44) btn_go = 1'b0;
        if (k == 100) begin
          chk({tag, " busy_noise"}, busy, 1);
          chk({tag, " mode_noise"}, mode_digit, m_mode);
        end
      end
      if (busy === 1'b0) break;
      if (k == d) begin
        alu_done   = 1'b1;
        alu_result = r;
        alu_flags  = f;
      end
    end
    alu_done = 1'b0;
    if (d >= 1 && d <= 255) begin
      m_res = r; m_flg = f; m_err = 1'b0;
    end else begin
      m_err = 1'b1;
      chk({tag, " err_at"}, first_err, 256);
    end
    ph = P_SHOW;
    chk({tag, " result"}, result, m_res);
    chk({tag, " flags"}, flags, m_flg);
    chk({tag, " err"}, err, m_err);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " state"}, dut.state, S_SHOW);
    chk({tag, " starts"}, start_cnt - s0, 1);
    chk({tag, " mode"}, mode_digit, m_mode);
  endtask

  task automatic set_mode(input int target);
    if (ph != P_MODE) mode_btn();
    for (int i = 0; i < 10 && m_mode != target; i++) mode_btn();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    cyc(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst mode_digit", mode_digit, 0);
    chk("rst alu_op", alu_op, 0);
    chk("rst result", result, 0);
    chk("rst flags", flags, 0);
    chk("rst err", err, 0);
    chk("rst busy", busy, 0);
    chk("rst alu_start", alu_start, 0);
    chk("rst alu_a", alu_a, 0);
    chk("rst alu_b", alu_b, 0);
    chk("rst state", dut.state, S_MODE);

    // Mode wrap: 11 presses give 1..9,0,1.
    for (int i = 1; i <= 11; i++) begin
      mode_btn();
      chk("wrap mode_digit", mode_digit, m_mode);
      chk("wrap alu_op", alu_op, m_mode);
    end

    // One long press must count once.
    press(1'b1, 1'b0, 50);
    m_mode = (m_mode + 1) % 10;
    chk("long press mode", mode_digit, m_mode);

    // go and mode together in MODE: go wins, mode untouched.
    press(1'b1, 1'b1, 4);
    ph = P_LA;
    chk("both mode", mode_digit, m_mode);
    chk("both state", dut.state, S_LOAD_A);
    mode_btn();
    chk("la->mode state", dut.state, S_MODE);
    chk("la->mode mode", mode_digit, m_mode);

    // Full operation: mode 3, A=5, B=9, done after 4 cycles.
    set_mode(3);
    chk("op mode", alu_op, 3);
    go_btn();
    sw_operand = 4'd5;
    go_btn();
    chk("op alu_a", alu_a, 5);
    sw_operand = 4'd9;
    launch(4, 4'hE, 4'h0, 1'b0, "op");
    chk("op result_e", result, 4'hE);

    // Timeout: operands retained through SHOW->LOAD_A, result kept.
    go_btn();
    chk("retain alu_a", alu_a, 5);
    chk("retain mode", mode_digit, 3);
    sw_operand = 4'd1;
    go_btn();
    sw_operand = 4'd2;
    launch(1000, 4'h3, 4'h5, 1'b0, "tmo");

    // Done in the last cycle before timeout wins.
    go_btn();
    go_btn();
    launch(255, 4'h7, 4'hA, 1'b0, "edge");

    // Presses during WAIT are ignored.
    go_btn();
    go_btn();
    launch(200, 4'hB, 4'h6, 1'b1, "noise");

    // Randomized operations.
    for (int it = 0; it < 12; it++) begin
      int d;
      if ($urandom_range(0, 1) == 1) begin
        mode_btn();
        repeat ($urandom_range(0, 12)) mode_btn();
        chk("rnd mode", mode_digit, m_mode);
      end
      sw_operand = N'($urandom);
      go_btn();
      sw_operand = N'($urandom);
      go_btn();
      chk("rnd alu_a", alu_a, m_a);
      sw_operand = N'($urandom);
      d = ($urandom_range(0, 5) == 0) ? int'($urandom_range(250, 262))
                                      : int'($urandom_range(1, 40));
      launch(d, N'($urandom), 4'($urandom), 1'b0, "rnd");
    end

    // Reset during WAIT, then a stale done.
    go_btn();
    go_btn();
    press(1'b0, 1'b1, 4);
    chk("wrst busy_before", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("wrst busy_in_rst", busy, 0);
    chk("wrst start_in_rst", alu_start, 0);
    @(negedge clk);
    model_reset();
    chk("wrst state", dut.state, S_MODE);
    chk("wrst result", result, 0);
    chk("wrst flags", flags, 0);
    chk("wrst mode", mode_digit, 0);
    chk("wrst alu_a", alu_a, 0);
    chk("wrst alu_b", alu_b, 0);
    chk("wrst err", err, 0);
    rst_n = 1'b1;
    cyc(2);
    alu_done   = 1'b1;
    alu_result = 4'hF;
    alu_flags  = 4'hF;
    @(negedge clk);
    alu_done = 1'b0;
    cyc(2);
    chk("stale result", result, m_res);
    chk("stale flags", flags, m_flg);
    chk("stale state", dut.state, S_MODE);
    chk("stale busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
